// File: rtl/uart_rx_if.sv
// Receive-side bundle between the UART controller and its serial receive core.
// The core takes the slave modport; the controller/FIFO side takes master.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [10:0]          baud_final_value;
    logic                 rx;
    logic                 rx_fifo_Full;
    logic [DATA_BITS-1:0] rx_fifo_dataIn;
    logic                 rx_fifo_writeEn;
    logic                 frame_error;
    logic                 overrun;
    logic                 busy;

    modport master (
        output baud_final_value,
        output rx,
        output rx_fifo_Full,
        input  rx_fifo_dataIn,
        input  rx_fifo_writeEn,
        input  frame_error,
        input  overrun,
        input  busy
    );

    modport slave (
        input  baud_final_value,
        input  rx,
        input  rx_fifo_Full,
        output rx_fifo_dataIn,
        output rx_fifo_writeEn,
        output frame_error,
        output overrun,
        output busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// 16x-oversampling 8N1 UART receiver with its own tick generator; each good
// frame becomes a one-cycle FIFO write strobe, bad frames a one-cycle error pulse.
module uart_rx_core #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

    // Oversample tick generator
    logic [10:0] cnt_q, cnt_d;
    logic        tick;

    // Synchroniser
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;

    // Deframer state
    state_e               state_q, state_d;
    logic [3:0]           s_cnt_q, s_cnt_d;
    logic [2:0]           n_q, n_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;

    // Registered outputs
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 wr_q, wr_d;
    logic                 fe_q, fe_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;

    logic stop_decide;

    // A count above a newly lowered terminal value free-runs through 2047 and wraps.
    assign tick  = (cnt_q == bus.baud_final_value);
    assign cnt_d = tick ? 11'd0 : cnt_q + 11'd1;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.rx};
    assign rx_s   = sync_q[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            sync_q  <= '1;
            state_q <= StIdle;
            s_cnt_q <= '0;
            n_q     <= '0;
            shift_q <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; the FSM only moves on tick cycles
    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_d     = n_q;
        shift_d = shift_q;
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d = StStart;
                        s_cnt_d = 4'd0;
                    end
                end
                StStart: begin
                    if (s_cnt_q == 4'd7) begin
                        s_cnt_d = 4'd0;
                        n_d     = 3'd0;
                        // High at mid start bit means it was only a glitch.
                        state_d = rx_s ? StIdle : StData;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
                StData: begin
                    if (s_cnt_q == 4'd15) begin
                        s_cnt_d = 4'd0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (n_q == LastBit) begin
                            state_d = StStop;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
                StStop: begin
                    // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                    if (s_cnt_q == 4'd15) begin
                        state_d = StIdle;
                        s_cnt_d = 4'd0;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output logic: pulses are decided on the mid-stop tick and registered
    always_comb begin
        stop_decide = tick && (state_q == StStop) && (s_cnt_q == 4'd15);
        wr_d        = stop_decide && rx_s && !bus.rx_fifo_Full;
        ovr_d       = stop_decide && rx_s && bus.rx_fifo_Full;
        fe_d        = stop_decide && !rx_s;
        data_d      = wr_d ? shift_q : data_q;
        busy_d      = (state_d != StIdle);
    end

    assign bus.rx_fifo_dataIn  = data_q;
    assign bus.rx_fifo_writeEn = wr_q;
    assign bus.frame_error     = fe_q;
    assign bus.overrun         = ovr_q;
    assign bus.busy            = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: a serial BFM drives frames while a negedge monitor
// checks every output pulse against a queue of expected events.
module tb_uart_rx_core;

    localparam int BitClks = 64;  // baud_final_value = 3 -> 4 clocks/tick, 16 ticks/bit
    localparam int KWr     = 0;
    localparam int KFe     = 1;
    localparam int KOvr    = 2;

    typedef struct {
        int       kind;
        logic [7:0] data;
        int       start;  // cycle of the start edge, or -1 when latency is not checked
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    int   mon_kind;
    int   mon_lat;
    logic saw_busy;
    logic [7:0] byte_v;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx_core #(
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        bus.rx = b;
        repeat (BitClks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] d, input int start);
        exp_t e;
        e.kind  = kind;
        e.data  = d;
        e.start = start;
        sb_q.push_back(e);
    endtask

    // Monitor: every pulse must match the head of the queue, last one cycle, be exclusive
    always @(negedge clk) begin
        if (bus.rx_fifo_writeEn || bus.frame_error || bus.overrun) begin
            check("pulse_onehot",
                  int'(bus.rx_fifo_writeEn) + int'(bus.frame_error) + int'(bus.overrun), 1);
            mon_kind = bus.rx_fifo_writeEn ? KWr : (bus.frame_error ? KFe : KOvr);
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got kind %0d data %0h expected none",
                         mon_kind, bus.rx_fifo_dataIn);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_kind", mon_kind, mon_e.kind);
                check("data_out", bus.rx_fifo_dataIn, mon_e.data);
                check("busy_at_pulse", bus.busy, 1'b0);
                if (mon_e.start >= 0) begin
                    mon_lat = cyc - mon_e.start;
                    tests++;
                    if (mon_lat < 598 || mon_lat > 614) begin
                        fails++;
                        $display("FAIL latency: got %0d clocks expected 598..614", mon_lat);
                    end
                end
            end
        end
    end

    initial begin
        bus.baud_final_value = 11'd3;
        bus.rx               = 1'b1;
        bus.rx_fifo_Full     = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_data", bus.rx_fifo_dataIn, 8'h00);
        check("rst_wr", bus.rx_fifo_writeEn, 1'b0);
        check("rst_fe", bus.frame_error, 1'b0);
        check("rst_ovr", bus.overrun, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        reset = 1'b0;
        idle(20);

        // 1: single frame with latency check
        expect_ev(KWr, 8'hA5, cyc);
        send_frame(8'hA5, 1'b1);
        idle(100);

        // 2: back-to-back frames
        expect_ev(KWr, 8'h00, -1);
        expect_ev(KWr, 8'hFF, -1);
        expect_ev(KWr, 8'h3C, -1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(100);

        // 3: short glitch
        saw_busy = 1'b0;
        for (int i = 0; i < 24 + 80; i++) begin
            bus.rx = (i < 24) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (bus.busy) saw_busy = 1'b1;
        end
        check("glitch_busy_seen", saw_busy, 1'b1);
        check("glitch_busy_clear", bus.busy, 1'b0);
        check("glitch_data_kept", bus.rx_fifo_dataIn, 8'h3C);

        // 4: framing error keeps previous data
        expect_ev(KFe, 8'h3C, -1);
        send_frame(8'h55, 1'b0);
        idle(300);
        check("fe_data_kept", bus.rx_fifo_dataIn, 8'h3C);

        // 5: overrun while FIFO full
        bus.rx_fifo_Full = 1'b1;
        expect_ev(KOvr, 8'h3C, -1);
        send_frame(8'h81, 1'b1);
        idle(100);
        bus.rx_fifo_Full = 1'b0;

        // 6: reset mid-frame, then a clean frame
        byte_v = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(byte_v[i]);
        bus.rx = byte_v[4];
        repeat (BitClks / 2) @(negedge clk);
        reset  = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_data", bus.rx_fifo_dataIn, 8'h00);
        check("mid_rst_wr", bus.rx_fifo_writeEn, 1'b0);
        check("mid_rst_fe", bus.frame_error, 1'b0);
        check("mid_rst_ovr", bus.overrun, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        reset = 1'b0;
        idle(200);
        check("post_rst_busy", bus.busy, 1'b0);
        expect_ev(KWr, 8'h96, cyc);
        send_frame(8'h96, 1'b1);
        idle(100);

        for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
        check("events_outstanding", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receive stage of the UART controller.
- Oversamples the `rx` pin at 16x the bit rate and deframes 8N1 characters (start, DATA_BITS data LSB-first, one stop).
- Delivers each byte as a one-cycle write strobe to the receive FIFO, whose output the APB interface reads through `rx_fifo_dataOut` / `rx_fifo_Empty`.
- Contains its own oversample tick generator, driven by the same `baud_final_value` the controller receives (650 at 100 MHz gives 16 x 9600).

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- SYNC_STAGES, 2, flops in the rx metastability synchroniser (at least 2).

Ports:
- clk  input  1  system clock (PCLK domain).
- reset  input  1  synchronous, active-high reset.
- baud_final_value  input  11  oversample divider terminal count; tick period = baud_final_value+1 clocks.
- rx  input  1  asynchronous serial line; idle high.
- rx_fifo_Full  input  1  receive FIFO full flag.
- rx_fifo_dataIn  output  DATA_BITS  received byte; held until the next good frame.
- rx_fifo_writeEn  output  1  one-cycle strobe: rx_fifo_dataIn valid, write to FIFO.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good byte dropped because the FIFO was full.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- All state updates on rising clk. reset has priority over everything, including mid-frame.
- Reset values:
  - all outputs 0; busy 0;
  - FSM = IDLE; tick counter 0;
  - synchroniser flops 1 (idle level).
- Tick generator:
  - 11-bit counter increments every clock.
  - When count == baud_final_value: counter returns to 0 and `tick` is asserted for that cycle.
  - baud_final_value = 0 gives a tick every clock.
  - A change of baud_final_value takes effect at the next compare. If the new value is below the current count, the counter runs on to 2047, wraps to 0 and then matches.
- `rx` passes through SYNC_STAGES flops to give `rx_s`. All decisions use `rx_s` only.
- FSM, advanced only on tick cycles. `s_cnt` is a 4-bit tick count, `n` a 3-bit bit index.
  - IDLE: if rx_s == 0, go to START with s_cnt = 0.
  - START: when s_cnt == 7 (mid start bit):
    - rx_s == 0: go to DATA with s_cnt = 0, n = 0.
    - rx_s == 1: glitch, return to IDLE with no outputs.
    - Otherwise s_cnt++.
  - DATA: when s_cnt == 15:
    - shift rx_s into shift[DATA_BITS-1], shifting right (LSB first); s_cnt = 0;
    - if n == DATA_BITS-1, go to STOP; otherwise n++.
    - Otherwise s_cnt++.
  - STOP: when s_cnt == 15 (mid stop bit), return to IDLE and act on rx_s:
    - rx_s == 1 and rx_fifo_Full == 0: rx_fifo_dataIn <= shift; rx_fifo_writeEn = 1 for the next cycle.
    - rx_s == 1 and rx_fifo_Full == 1: overrun = 1 for the next cycle; rx_fifo_dataIn is not updated; no write.
    - rx_s == 0: frame_error = 1 for the next cycle; data is discarded.
    - Otherwise s_cnt++.
- Pulse outputs are registered, high for exactly one clock, and mutually exclusive.
- rx_fifo_Full is sampled only on the STOP decision cycle.
- Latency: the write strobe occurs 1 clock after the mid-stop tick, i.e. about 9.5 bit times plus SYNC_STAGES+1 clocks after the falling start edge.
- Back-to-back frames:
  - returning to IDLE at mid-stop lets a start edge arriving half a bit later be caught;
  - a continuous low line after a framing error restarts START detection, which is how a break is seen.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Setup for all scenarios: baud_final_value = 3 (4 clocks per tick, 64 clocks per bit); rx driven by a bench BFM.
1. Reset, then frame 0xA5 → rx_fifo_dataIn = 8'hA5, rx_fifo_writeEn high exactly 1 cycle, 606 ±8 clocks after the start edge; frame_error = 0, overrun = 0; busy drops the same cycle.
2. Frames 0x00, 0xFF, 0x3C sent back-to-back with no idle gap → three strobes carrying 00, FF, 3C in order; no errors.
3. 24-clock low glitch (shorter than half a bit) on idle rx → FSM returns to IDLE; no strobe, no error; busy pulses then clears.
4. Frame 0x55 with stop bit forced low → frame_error = 1 for 1 cycle; no strobe; rx_fifo_dataIn keeps the previous value.
5. rx_fifo_Full = 1 during frame 0x81 → overrun = 1 for 1 cycle; no strobe; rx_fifo_dataIn unchanged.
6. reset asserted during data bit 4 of 0xC3, then released, then 0x96 sent → all outputs 0 during reset; next strobe carries 8'h96; no stale bits.
